id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register of the pipelined RV32I core. Captures the decoder's control outputs plus the decode-stage operands each cycle.
//  Detects load-use hazards and inserts a bubble. Honours downstream hold and branch flush. Presents registered control/data to EX.
//  Also keeps a saturating count of load-use bubbles for performance monitoring.
// PARAMETERS
//  XLEN   32  datapath width (PC, operands, immediate)
//  CNT_W  16  width of bubble counter BUBBLE_CNT
// PORTS
//  CLK           in   1      system clock, rising edge
//  RST           in   1      asynchronous reset, active-high
//  ID_VALID      in   1      decode slot holds a real instruction
//  ID_PC         in   XLEN   PC of decode instruction
//  ID_IR         in   32     instruction word in decode
//  ID_RS1_DATA   in   XLEN   register-file read port 1
//  ID_RS2_DATA   in   XLEN   register-file read port 2
//  ID_IMM        in   XLEN   immediate selected for ID_IR
//  ID_REG_WRITE  in   1      decoder control (also ID_MEM_WE2, ID_MEM_RDEN2: 1 each)
//  ID_ALU_FUN    in   4      decoder ALU function
//  ID_ALU_SRCA   in   1      decoder ALU A-select
//  ID_ALU_SRCB   in   2      decoder ALU B-select
//  ID_RF_WR_SEL  in   2      decoder writeback select
//  HOLD          in   1      downstream stall: freeze EX register
//  FLUSH         in   1      taken branch/jump resolved in EX: kill EX contents
//  EX_VALID      out  1      EX slot holds a real instruction
//  EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM  out XLEN  registered copies
//  EX_RD, EX_RS1, EX_RS2  out 5  IR[11:7], IR[19:15], IR[24:20] (for forwarding)
//  EX_OPCODE     out  7      IR[6:0];  EX_FUNCT3 out 3  IR[14:12]
//  EX_REG_WRITE, EX_MEM_WE2, EX_MEM_RDEN2, EX_ALU_FUN, EX_ALU_SRCA, EX_ALU_SRCB, EX_RF_WR_SEL  out  registered control, widths as ID_*
//  STALL_ID      out  1      freeze PC and IF/ID register this cycle (combinational)
//  BUBBLE_CNT    out  CNT_W  load-use bubbles inserted, saturating
// BEHAVIOUR
//  Reset (async, RST=1): every EX_* output = 0, EX_VALID = 0, BUBBLE_CNT = 0. Outputs are 0 while RST is held, and the first capture occurs on the first rising edge after deassertion.
//  rs1 used: ID opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
//  rs2 used: opcode in {R 0110011, STORE 0100011, BRANCH 1100011}.
//  HAZ (comb) = ID_VALID & EX_VALID & EX_MEM_RDEN2 & EX_RD!=0 & ((rs1 used & EX_RD==ID_IR[19:15]) | (rs2 used & EX_RD==ID_IR[24:20])).
//  Per-edge update, priority highest first:
//   1 FLUSH=1: load bubble (EX_VALID=0, all control outputs 0; data fields don't-care, drive 0). FLUSH overrides HOLD.
//   2 HOLD=1: all EX_* registers retain their value.
//   3 HAZ=1: load bubble. BUBBLE_CNT += 1, saturating at 2^CNT_W-1.
//   4 otherwise: capture all ID_* fields, with EX_VALID=ID_VALID. If ID_VALID=0, control outputs are forced to 0.
//  STALL_ID = ~FLUSH & (HOLD | HAZ). While FLUSH=1, STALL_ID=0 because the ID instruction is being squashed upstream.
//  Latency: one cycle from ID_* to EX_*. A load followed by a dependent instruction costs exactly one bubble.
//  In the cycle after a bubble, EX_MEM_RDEN2=0, so HAZ drops and the dependent instruction advances, taking its operand by forwarding.
//  A bubble never writes (REG_WRITE=0, MEM_WE2=0), which guarantees no architectural side effect.
//  Register x0 as destination never causes a hazard.
//  BUBBLE_CNT counts only hazard bubbles, not flushes. It holds its value while HOLD=1.
// TESTING
//  T1 reset mid-stream: assert RST while EX_VALID=1, REG_WRITE=1 -> all outputs 0 immediately (before next edge), BUBBLE_CNT=0.
//  T2 load-use: EX holds lw x5 (RDEN2=1, RD=5); ID presents add x6,x5,x1 -> STALL_ID=1, next edge EX_VALID=0, BUBBLE_CNT=1; following edge EX_RD=6, EX_ALU_FUN=0000.
//  T3 no false hazard: EX lw x0, ID add x6,x0,x1 -> STALL_ID=0, add captured. EX lw x5, ID lui x5 -> STALL_ID=0.
//  T4 store rs2 dep: EX lw x7, ID sw x7,0(x2) -> hazard, one bubble. EX lw x7, ID sw x2,0(x7) -> hazard via rs1.
//  T5 FLUSH+HOLD+HAZ same cycle -> EX_VALID=0, STALL_ID=0, BUBBLE_CNT unchanged. HOLD alone for 3 cycles -> EX_* constant, STALL_ID=1.
//  T6 saturation (CNT_W=4): 17 consecutive load-use pairs -> BUBBLE_CNT stops at 15.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the RV32I core: captures decode operands and control,
// inserts a bubble on load-use hazards, honours hold/flush, and counts hazard bubbles.
`default_nettype none

module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [31:0]      id_ir_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_we2_i,
  input  logic             id_mem_rden2_i,
  input  logic [3:0]       id_alu_fun_i,
  input  logic             id_alu_srca_i,
  input  logic [1:0]       id_alu_srcb_i,
  input  logic [1:0]       id_rf_wr_sel_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [6:0]       ex_opcode_o,
  output logic [2:0]       ex_funct3_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_we2_o,
  output logic             ex_mem_rden2_o,
  output logic [3:0]       ex_alu_fun_o,
  output logic             ex_alu_srca_o,
  output logic [1:0]       ex_alu_srcb_o,
  output logic [1:0]       ex_rf_wr_sel_o,
  output logic             stall_id_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             valid_q,  valid_d;
  logic [XLEN-1:0]  pc_q,     pc_d;
  logic [XLEN-1:0]  rs1d_q,   rs1d_d;
  logic [XLEN-1:0]  rs2d_q,   rs2d_d;
  logic [XLEN-1:0]  imm_q,    imm_d;
  logic [24:0]      ir_q,     ir_d;
  logic             rw_q,     rw_d;
  logic             we_q,     we_d;
  logic             re_q,     re_d;
  logic [3:0]       fun_q,    fun_d;
  logic             srca_q,   srca_d;
  logic [1:0]       srcb_q,   srcb_d;
  logic [1:0]       sel_q,    sel_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic       rs1_used;
  logic       rs2_used;
  logic       haz;
  logic [6:0] id_op;
  logic       unused_ir_hi;

  assign id_op        = id_ir_i[6:0];
  assign unused_ir_hi = ^id_ir_i[31:25];

  assign rs1_used = (id_op != OP_LUI) && (id_op != OP_AUIPC) && (id_op != OP_JAL);
  assign rs2_used = (id_op == OP_R) || (id_op == OP_STORE) || (id_op == OP_BRANCH);

  assign haz = id_valid_i && valid_q && re_q && (ir_q[11:7] != 5'd0) &&
               ((rs1_used && (ir_q[11:7] == id_ir_i[19:15])) ||
                (rs2_used && (ir_q[11:7] == id_ir_i[24:20])));

  // A flushed ID instruction is squashed upstream, so it must not be frozen.
  assign stall_id_o = !flush_i && (hold_i || haz);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    ir_d    = ir_q;
    rw_d    = rw_q;
    we_d    = we_q;
    re_d    = re_q;
    fun_d   = fun_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    if (flush_i || (!hold_i && haz)) begin
      valid_d = 1'b0;
      pc_d    = '0;
      rs1d_d  = '0;
      rs2d_d  = '0;
      imm_d   = '0;
      ir_d    = '0;
      rw_d    = 1'b0;
      we_d    = 1'b0;
      re_d    = 1'b0;
      fun_d   = '0;
      srca_d  = 1'b0;
      srcb_d  = '0;
      sel_d   = '0;
      if (!flush_i && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!hold_i) begin
      valid_d = id_valid_i;
      pc_d    = id_pc_i;
      rs1d_d  = id_rs1_data_i;
      rs2d_d  = id_rs2_data_i;
      imm_d   = id_imm_i;
      ir_d    = id_ir_i[24:0];
      // Control of an empty decode slot is zeroed so it can never write anything.
      rw_d    = id_valid_i & id_reg_write_i;
      we_d    = id_valid_i & id_mem_we2_i;
      re_d    = id_valid_i & id_mem_rden2_i;
      fun_d   = id_valid_i ? id_alu_fun_i   : 4'd0;
      srca_d  = id_valid_i & id_alu_srca_i;
      srcb_d  = id_valid_i ? id_alu_srcb_i  : 2'd0;
      sel_d   = id_valid_i ? id_rf_wr_sel_i : 2'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      ir_q    <= '0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      fun_q   <= '0;
      srca_q  <= 1'b0;
      srcb_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      ir_q    <= ir_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      re_q    <= re_d;
      fun_q   <= fun_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_pc_o        = pc_q;
  assign ex_rs1_data_o  = rs1d_q;
  assign ex_rs2_data_o  = rs2d_q;
  assign ex_imm_o       = imm_q;
  assign ex_rd_o        = ir_q[11:7];
  assign ex_rs1_o       = ir_q[19:15];
  assign ex_rs2_o       = ir_q[24:20];
  assign ex_opcode_o    = ir_q[6:0];
  assign ex_funct3_o    = ir_q[14:12];
  assign ex_reg_write_o = rw_q;
  assign ex_mem_we2_o   = we_q;
  assign ex_mem_rden2_o = re_q;
  assign ex_alu_fun_o   = fun_q;
  assign ex_alu_srca_o  = srca_q;
  assign ex_alu_srcb_o  = srcb_q;
  assign ex_rf_wr_sel_o = sel_q;
  assign bubble_cnt_o   = cnt_q;

endmodule

`default_nettype wire
